unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Sequences a single-ported unified memory between the instruction-fetch port and the load/store data port of the core. Data requests (driven by the controller's memRd/memWrt decode) normally win; fetch is protected from starvation by a bounded loss counter. One transaction is in flight at a time. The memory has fixed read latency, and each completion is signalled back to its owner. The core stalls on the missing grant/response.

## Interface
- LAT, 2: memory latency in cycles from mem_en to valid mem_rdata; legal range 1..8.
- STARVE_MAX, 4: consecutive fetch losses after which fetch wins; legal range 1..15.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req / if_addr  in  1 / 32  fetch request (read only); level, held until if_gnt
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid / if_rdata  out  1 / 32  fetch completion pulse and data
- d_req / d_we / d_addr / d_wdata / d_be  in  1 / 1 / 32 / 32 / 4  data request; d_we=1 is a store; held until d_gnt
- d_gnt  out  1  data request accepted this cycle
- d_rvalid / d_rdata  out  1 / 32  data completion pulse (loads and stores); d_rdata is 0 for stores
- mem_en / mem_we / mem_addr / mem_wdata / mem_be  out  1 / 1 / 32 / 32 / 4  memory command
- mem_rdata  in  32  valid exactly LAT cycles after mem_en
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- States: IDLE, WAIT, RESP.
- Acceptance is legal only in IDLE or RESP.
- Arbitration, when both requests are high:
  - d wins, unless starve_cnt == STARVE_MAX, in which case if wins.
  - A single requester always wins.
- Accept cycle:
  - Exactly one of if_gnt/d_gnt = 1.
  - mem_en = 1, and the mem_* fields are driven combinationally from the winner (mem_we = 0 and mem_be = 4'hF for fetch).
  - owner and we are registered.
  - Next state is WAIT with lat_cnt = LAT-1.
- WAIT: decrement lat_cnt. When it is 0, capture mem_rdata into the response register (0 if we), then go to RESP.
- RESP: owner's rvalid = 1 for exactly one cycle, and its rdata = captured data.
  - The same cycle may accept a new request; that gives back-to-back operation.
  - Otherwise go to IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on any cycle where d_gnt = 1 and if_req = 1.
  - Clears on if_gnt.
  - Holds otherwise.
- mem_addr is passed unmodified; alignment is the requester's responsibility.
- Request fields are sampled only in the grant cycle; changes after grant are ignored.

## Timing
- Reset: state = IDLE, lat_cnt = 0, starve_cnt = 0, owner = fetch, response register = 0.
  - All outputs are 0 during the rst cycle and the following cycle unless a request is accepted then.
  - gnt and mem_en are gated by !rst.
- Latency:
  - Accept at cycle T.
  - mem_rdata is sampled at T+LAT.
  - rvalid is asserted at T+LAT+1.
  - The next accept is possible at T+LAT+1; throughput is one transaction per LAT+1 cycles.
- Reset during WAIT/RESP: the transaction is dropped, no rvalid is ever issued for it, and the requester must re-request.
- A request raised in the same cycle as a RESP for the other port is eligible immediately.
- if_rvalid and d_rvalid are never high together; if_gnt and d_gnt are never high together.
- STARVE_MAX = 1: fetch and data strictly alternate under continuous contention.

## Structure
- Shared package `mem_arb_pkg`:
  - state typedef {IDLE, WAIT, RESP}
  - owner typedef {OWN_IF, OWN_D}
  - ADDR_W = 32, DATA_W = 32, BE_W = 4
- One sub-module, `mem_arb_pick`: combinational winner select from if_req, d_req and starve_cnt == STARVE_MAX.
- FSM, counters and response register live in the top module.

## Test plan
- Reset: with LAT = 2, STARVE_MAX = 4:
  - Drive rst = 1 for 2 cycles with both reqs high.
  - Required: no gnt, mem_en = 0 and busy = 0 during the rst cycles.
  - Required: the first grant is to d, in the first cycle after rst falls.
- Fetch only:
  - if_req = 1, if_addr = 0x100, memory returns 0x00500093 at T+2.
  - Required: if_gnt at T; if_rvalid = 1 with if_rdata = 0x00500093 at T+3; busy high T+1..T+3.
- Store:
  - d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF, d_be = 4'b0011.
  - Required: mem_we = 1 and mem_be = 4'b0011 at the grant cycle.
  - Required: d_rvalid = 1 with d_rdata = 0 three cycles later.
- Starvation:
  - Both reqs held high continuously.
  - Required grant order: d, d, d, d, if, d, d, d, d, if.
  - Required: each grant falls in the RESP cycle of the previous transaction (spacing LAT+1 = 3 cycles).
- Reset mid-flight:
  - Assert rst at T+1 after a fetch grant.
  - Required: no if_rvalid at T+3; state = IDLE and starve_cnt = 0 after rst.
- LAT = 1 build: a load to 0x40 returning 0x12345678 gives d_rvalid with that data 2 cycles after d_gnt.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the unified memory arbiter.
//   state_t : arbiter sequencing state (IDLE, WAIT, RESP)
//   owner_t : which port owns the in-flight transaction
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between fetch and data.
//   i_if_req      : fetch request level
//   i_d_req       : data request level
//   i_starve_full : fetch has lost the maximum allowed number of times
//   o_pick_if     : fetch would win if acceptance is legal
//   o_pick_d      : data would win if acceptance is legal
module mem_arb_pick (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_starve_full,
  output logic o_pick_if,
  output logic o_pick_d
);
  // Data wins a contended cycle unless fetch has been starved out.
  assign o_pick_d  = i_d_req && !(i_if_req && i_starve_full);
  assign o_pick_if = i_if_req && !o_pick_d;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported fixed-latency memory between
// the instruction-fetch port and the load/store port, one transaction at a time.
//   clk, rst                           : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt           : fetch request and acceptance
//   if_rvalid/if_rdata                 : fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata/d_be     : data request (d_we=1 store)
//   d_gnt, d_rvalid/d_rdata            : data acceptance and completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be, mem_rdata : memory command/return
//   busy                               : a transaction is in flight
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [3:0] LAT_M1     = 4'(LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_lat_cnt, w_lat_nxt;
  logic [3:0]        r_starve_cnt;
  owner_t            r_owner;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata;
  logic              w_accept_ok, w_accept, w_capture, w_resp;
  logic              w_pick_if, w_pick_d;

  mem_arb_pick u_pick (
    .i_if_req      (if_req),
    .i_d_req       (d_req),
    .i_starve_full (r_starve_cnt == STARVE_LIM),
    .o_pick_if     (w_pick_if),
    .o_pick_d      (w_pick_d)
  );

  // A new request may be taken when idle or while the previous one responds.
  assign w_accept_ok = !rst && (r_state == IDLE || r_state == RESP);
  assign if_gnt      = w_accept_ok && w_pick_if;
  assign d_gnt       = w_accept_ok && w_pick_d;
  assign w_accept    = if_gnt || d_gnt;

  // Memory command is a straight mux of the winner's request fields.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
      mem_be   = '1;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = WAIT;
          w_lat_nxt   = LAT_M1;
        end
      end
      WAIT: begin
        if (r_lat_cnt == 4'd0) begin
          w_state_nxt = RESP;
          w_capture   = 1'b1;
        end else begin
          w_lat_nxt = r_lat_cnt - 4'd1;
        end
      end
      RESP: begin
        if (w_accept) begin
          w_state_nxt = WAIT;
          w_lat_nxt   = LAT_M1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= 4'd0;
      r_starve_cnt <= 4'd0;
      r_owner      <= OWN_IF;
      r_we         <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      if (w_accept) begin
        r_owner <= if_gnt ? OWN_IF : OWN_D;
        r_we    <= mem_we;
      end
      // Stores complete with zero data so the core never sees stale read data.
      if (w_capture) r_rdata <= r_we ? '0 : mem_rdata;
      if (if_gnt) r_starve_cnt <= 4'd0;
      else if (d_gnt && if_req && r_starve_cnt != STARVE_LIM)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Gating with !rst drops a response that is cut off by reset.
  assign w_resp    = !rst && (r_state == RESP);
  assign if_rvalid = w_resp && (r_owner == OWN_IF);
  assign d_rvalid  = w_resp && (r_owner == OWN_D);
  assign if_rdata  = if_rvalid ? r_rdata : '0;
  assign d_rdata   = d_rvalid ? r_rdata : '0;
  assign busy      = !rst && (r_state != IDLE);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // ---------------- DUT A: LAT=2, STARVE_MAX=4 ----------------
  logic        rst, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic        mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_be, mem_be;

  unified_mem_arbiter #(.LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // ---------------- DUT B: LAT=1 ----------------
  logic        rst_b, if_req_b, if_gnt_b, if_rvalid_b, d_req_b, d_we_b, d_gnt_b, d_rvalid_b;
  logic        mem_en_b, mem_we_b, busy_b;
  logic [31:0] if_addr_b, if_rdata_b, d_addr_b, d_wdata_b, d_rdata_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  d_be_b, mem_be_b;

  unified_mem_arbiter #(.LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
    .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_be(d_be_b),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_be(mem_be_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b)
  );

  // Memory contents: fixed words at known addresses, a pattern elsewhere.
  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0040: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Fixed-latency memory: data is valid only in the exact return cycle.
  logic        va0 = 1'b0, va1 = 1'b0, vb0 = 1'b0;
  logic [31:0] aa0 = '0, aa1 = '0, ab0 = '0;
  always @(posedge clk) begin
    va0 <= mem_en;   aa0 <= mem_addr;
    va1 <= va0;      aa1 <= aa0;
    vb0 <= mem_en_b; ab0 <= mem_addr_b;
  end
  assign mem_rdata   = va1 ? mem_lookup(aa1) : 32'hBAD0_BAD0;
  assign mem_rdata_b = vb0 ? mem_lookup(ab0) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_if, prev_if;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = '0; d_be = 4'hF;
    rst_b = 1'b1; if_req_b = 1'b0; if_addr_b = '0;
    d_req_b = 1'b0; d_we_b = 1'b0; d_addr_b = '0; d_wdata_b = '0; d_be_b = 4'hF;

    // ---------------- reset with both requests high ----------------
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("rst_d_gnt",  {31'd0, d_gnt},  32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      tick();
    end
    rst = 1'b0; rst_b = 1'b0;
    smp();
    chk("first_d_gnt",  {31'd0, d_gnt},  32'd1);
    chk("first_if_gnt", {31'd0, if_gnt}, 32'd0);
    tick(); if_req = 1'b0; d_req = 1'b0;
    smp(); chk("ld_busy_t1", {31'd0, busy}, 32'd1);
    tick(); smp(); chk("ld_rvalid_t2", {31'd0, d_rvalid}, 32'd0);
    tick(); smp();
    chk("ld_rvalid_t3", {31'd0, d_rvalid}, 32'd1);
    chk("ld_rdata_t3",  d_rdata, 32'hA5A5_A6A5);
    tick();

    // ---------------- fetch only ----------------
    if_req = 1'b1; if_addr = 32'h100;
    smp();
    chk("f_if_gnt",  {31'd0, if_gnt}, 32'd1);
    chk("f_mem_en",  {31'd0, mem_en}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we",  {31'd0, mem_we}, 32'd0);
    chk("f_mem_be",  {28'd0, mem_be}, 32'hF);
    tick(); if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    smp(); chk("f_busy_t1", {31'd0, busy}, 32'd1);
    chk("f_rvalid_t1", {31'd0, if_rvalid}, 32'd0);
    tick(); smp(); chk("f_busy_t2", {31'd0, busy}, 32'd1);
    tick(); smp();
    chk("f_busy_t3",   {31'd0, busy}, 32'd1);
    chk("f_rvalid_t3", {31'd0, if_rvalid}, 32'd1);
    chk("f_rdata_t3",  if_rdata, 32'h0050_0093);
    chk("f_d_rvalid_t3", {31'd0, d_rvalid}, 32'd0);
    tick(); smp();
    chk("f_busy_t4",   {31'd0, busy}, 32'd0);
    chk("f_rvalid_t4", {31'd0, if_rvalid}, 32'd0);
    tick();

    // ---------------- store ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    smp();
    chk("st_d_gnt",     {31'd0, d_gnt}, 32'd1);
    chk("st_mem_we",    {31'd0, mem_we}, 32'd1);
    chk("st_mem_be",    {28'd0, mem_be}, 32'h3);
    chk("st_mem_addr",  mem_addr, 32'h2000);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick(); d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
    tick(); tick(); smp();
    chk("st_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("st_rdata",  d_rdata, 32'd0);
    tick();

    // ---------------- starvation: d,d,d,d,if,d,d,d,d,if ----------------
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    prev_if = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_if = (k == 4 || k == 9);
      smp();
      chk($sformatf("sv_if_gnt_%0d", k), {31'd0, if_gnt}, {31'd0, exp_if});
      chk($sformatf("sv_d_gnt_%0d", k),  {31'd0, d_gnt},  {31'd0, !exp_if});
      if (k > 0) begin
        chk($sformatf("sv_if_rvalid_%0d", k), {31'd0, if_rvalid}, {31'd0, prev_if});
        chk($sformatf("sv_d_rvalid_%0d", k),  {31'd0, d_rvalid},  {31'd0, !prev_if});
      end
      tick();
      if (k == 9) begin if_req = 1'b0; d_req = 1'b0; end
      smp();
      chk($sformatf("sv_nogrant_%0d", k), {30'd0, if_gnt, d_gnt}, 32'd0);
      tick(); smp();
      chk($sformatf("sv_nogrant2_%0d", k), {30'd0, if_gnt, d_gnt}, 32'd0);
      tick();
      prev_if = exp_if;
    end
    smp();
    chk("sv_last_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("sv_last_if_rdata",  if_rdata, 32'h0050_0093);
    tick();

    // ---------------- reset mid-flight (contended data grant) ----------------
    if_req = 1'b1; d_req = 1'b1;
    smp(); chk("rd_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick(); if_req = 1'b0; d_req = 1'b0; rst = 1'b1;
    smp(); chk("rd_busy_rst", {31'd0, busy}, 32'd0);
    tick(); rst = 1'b0;
    smp();
    chk("rd_state",  {30'd0, dut_a.r_state}, {30'd0, IDLE});
    chk("rd_starve", {28'd0, dut_a.r_starve_cnt}, 32'd0);
    tick(); smp(); chk("rd_no_rvalid", {31'd0, d_rvalid}, 32'd0);
    tick();

    // ---------------- reset mid-flight (fetch) ----------------
    if_req = 1'b1; if_addr = 32'h100;
    smp(); chk("rf_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick(); if_req = 1'b0; rst = 1'b1;
    smp(); chk("rf_busy_rst", {31'd0, busy}, 32'd0);
    tick(); rst = 1'b0;
    smp(); chk("rf_rvalid_t2", {31'd0, if_rvalid}, 32'd0);
    chk("rf_busy_t2", {31'd0, busy}, 32'd0);
    tick(); smp(); chk("rf_rvalid_t3", {31'd0, if_rvalid}, 32'd0);
    chk("rf_state",  {30'd0, dut_a.r_state}, {30'd0, IDLE});
    chk("rf_starve", {28'd0, dut_a.r_starve_cnt}, 32'd0);
    tick();

    // ---------------- LAT=1 load ----------------
    d_req_b = 1'b1; d_addr_b = 32'h40; d_wdata_b = 32'h0000_1111;
    smp();
    chk("l1_d_gnt",  {31'd0, d_gnt_b}, 32'd1);
    chk("l1_if_gnt", {31'd0, if_gnt_b}, 32'd0);
    chk("l1_mem_we", {31'd0, mem_we_b}, 32'd0);
    chk("l1_mem_be", {28'd0, mem_be_b}, 32'hF);
    chk("l1_mem_wdata", mem_wdata_b, 32'h0000_1111);
    tick(); d_req_b = 1'b0;
    smp();
    chk("l1_busy_t1",   {31'd0, busy_b}, 32'd1);
    chk("l1_rvalid_t1", {31'd0, d_rvalid_b}, 32'd0);
    tick(); smp();
    chk("l1_rvalid_t2", {31'd0, d_rvalid_b}, 32'd1);
    chk("l1_rdata_t2",  d_rdata_b, 32'h1234_5678);
    chk("l1_if_side",   {31'd0, if_rvalid_b} | if_rdata_b, 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
